knight_rider_gen: RTL

//  Upstream pattern source for the ALU output mux. Drives the 8-bit knight-rider operand

---
 rtl/knight_rider_gen_if.sv | 25 ++
 rtl/knight_rider_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/knight_rider_gen_if.sv
// Control/pattern bundle between the ALU mode decoder (master) and the
// knight-rider pattern generator (slave).
interface knight_rider_gen_if;
    logic       en;
    logic [1:0] speed;
    logic [7:0] nightrid;
    logic       step_tick;
    logic       dir;

    modport master (
        output en,
        output speed,
        input  nightrid,
        input  step_tick,
        input  dir
    );

    modport slave (
        input  en,
        input  speed,
        output nightrid,
        output step_tick,
        output dir
    );
endinterface

// File: rtl/knight_rider_gen.sv
// Knight-rider LED scanner: one lit bit bouncing across 8 LEDs at a
// programmable step rate, with an optional dwell at each end.
module knight_rider_gen #(
    parameter int TICK_DIV    = 25_000_000,
    parameter int DWELL_STEPS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    knight_rider_gen_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_STEPS > 0) ? $clog2(DWELL_STEPS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_L,
        DWELL_L,
        SCAN_R,
        DWELL_R
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      nr_q, nr_d;
    logic            tick_q, tick_d;
    logic            dir_q, dir_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   dwell_q, dwell_d;

    logic [PW-1:0]   period_m1;
    logic            tick;
    logic [7:0]      shl, shr;

    // Terminal count uses >= so that shortening the period mid-run fires at once.
    always_comb begin
        period_m1 = PW'((TICK_DIV >> bus.speed) - 1);
        tick      = (state_q != IDLE) && (presc_q >= period_m1);
        shl       = nr_q << 1;
        shr       = nr_q >> 1;
    end

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        dwell_d = dwell_q;
        tick_d  = 1'b0;

        if (state_q == IDLE) begin
            presc_d = '0;
            dwell_d = '0;
            nr_d    = 8'h00;
            dir_d   = 1'b0;
            if (bus.en) begin
                state_d = SCAN_L;
                nr_d    = 8'h01;
            end
        end else if (!bus.en) begin
            // Disable beats a coincident tick: no shift, no pulse.
            state_d = IDLE;
            nr_d    = 8'h00;
            dir_d   = 1'b0;
            presc_d = '0;
            dwell_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            tick_d  = tick;
            if (tick) begin
                case (state_q)
                    SCAN_L: begin
                        nr_d = shl;
                        if (shl == 8'h80) begin
                            dir_d   = 1'b1;
                            dwell_d = '0;
                            state_d = (DWELL_STEPS == 0) ? SCAN_R : DWELL_L;
                        end
                    end
                    DWELL_L: begin
                        if (int'(dwell_q) == DWELL_STEPS - 1) begin
                            state_d = SCAN_R;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                    SCAN_R: begin
                        nr_d = shr;
                        if (shr == 8'h01) begin
                            dir_d   = 1'b0;
                            dwell_d = '0;
                            state_d = (DWELL_STEPS == 0) ? SCAN_L : DWELL_R;
                        end
                    end
                    DWELL_R: begin
                        if (int'(dwell_q) == DWELL_STEPS - 1) begin
                            state_d = SCAN_L;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        nr_d    = 8'h00;
                        dir_d   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nr_q    <= 8'h00;
            tick_q  <= 1'b0;
            dir_q   <= 1'b0;
            presc_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.nightrid  = nr_q;
    assign bus.step_tick = tick_q;
    assign bus.dir       = dir_q;

endmodule
